// File: rtl/div_pipe_unit_pkg.sv
// Shared types and helpers for the pipelined RV32M divide unit.
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    function automatic logic is_signed_op(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_pipe_unit_divider_unsigned.sv
// Combinational 32-bit unsigned restoring divider core (quotient and remainder).
module divider_unsigned (
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quotient,
    output logic [31:0] o_remainder
);

    always_comb begin
        logic [32:0] rem;
        logic [31:0] quo;
        rem = '0;
        quo = '0;
        // One shift-compare-subtract step per dividend bit, MSB first.
        for (int i = 31; i >= 0; i--) begin
            rem = {rem[31:0], i_dividend[i]};
            if (rem >= {1'b0, i_divisor}) begin
                rem    = rem - {1'b0, i_divisor};
                quo[i] = 1'b1;
            end
        end
        o_quotient  = quo;
        o_remainder = rem[31:0];
    end

endmodule

// File: rtl/div_pipe_unit.sv
// Two-stage RV32M divide: operand conditioning into stage A, then core + sign/special fixup
// into the output register, with valid/ready handshakes on both sides.
module div_pipe_unit
    import div_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [31:0]      i_rs1,
    input  logic [31:0]      i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag
);

    logic             a_valid_q, a_valid_d;
    div_op_e          a_op_q, a_op_d;
    logic [TAG_W-1:0] a_tag_q, a_tag_d;
    logic             a_neg_quo_q, a_neg_quo_d;
    logic             a_neg_rem_q, a_neg_rem_d;
    logic             a_div0_q, a_div0_d;
    logic [31:0]      a_rs1_q, a_rs1_d;
    logic [31:0]      a_abs1_q, a_abs1_d;
    logic [31:0]      a_abs2_q, a_abs2_d;

    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             out_adv, a_adv, accept, sgn_in;
    div_op_e          op_in;
    logic [31:0]      core_quo, core_rem, quo_fix, rem_fix;

    divider_unsigned u_core (
        .i_dividend  (a_abs1_q),
        .i_divisor   (a_abs2_q),
        .o_quotient  (core_quo),
        .o_remainder (core_rem)
    );

    always_comb begin
        out_adv = !out_valid_q || i_ready;
        a_adv   = a_valid_q && out_adv;
        o_ready = rst_n && (!a_valid_q || out_adv);
        accept  = i_valid && o_ready;
        op_in   = div_op_e'(i_op);
        sgn_in  = is_signed_op(op_in);

        a_valid_d   = a_valid_q;
        a_op_d      = a_op_q;
        a_tag_d     = a_tag_q;
        a_neg_quo_d = a_neg_quo_q;
        a_neg_rem_d = a_neg_rem_q;
        a_div0_d    = a_div0_q;
        a_rs1_d     = a_rs1_q;
        a_abs1_d    = a_abs1_q;
        a_abs2_d    = a_abs2_q;

        // Stage A: capture op and absolute-value operands
        if (o_ready) begin
            a_valid_d = accept;
        end
        if (i_flush) begin
            a_valid_d = 1'b0;
        end
        if (accept) begin
            a_op_d      = op_in;
            a_tag_d     = i_tag;
            a_neg_quo_d = sgn_in && (i_rs1[31] ^ i_rs2[31]);
            a_neg_rem_d = sgn_in && i_rs1[31];
            a_div0_d    = (i_rs2 == 32'd0);
            a_rs1_d     = i_rs1;
            a_abs1_d    = (sgn_in && i_rs1[31]) ? (32'd0 - i_rs1) : i_rs1;
            a_abs2_d    = (sgn_in && i_rs2[31]) ? (32'd0 - i_rs2) : i_rs2;
        end

        // Output stage: sign fixup and divide-by-zero override
        quo_fix = a_neg_quo_q ? (32'd0 - core_quo) : core_quo;
        rem_fix = a_neg_rem_q ? (32'd0 - core_rem) : core_rem;
        if (a_div0_q) begin
            quo_fix = DIV0_QUOTIENT;
            rem_fix = a_rs1_q;
        end

        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        if (out_adv) begin
            out_valid_d = a_valid_q;
        end
        if (i_flush) begin
            out_valid_d = 1'b0;
        end
        if (a_adv) begin
            out_result_d = is_rem_op(a_op_q) ? rem_fix : quo_fix;
            out_tag_d    = a_tag_q;
        end

        o_valid  = out_valid_q;
        o_result = out_result_q;
        o_tag    = out_tag_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_valid_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
        end else begin
            a_valid_q    <= a_valid_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    // Stage A payload only matters while a_valid_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        a_op_q      <= a_op_d;
        a_tag_q     <= a_tag_d;
        a_neg_quo_q <= a_neg_quo_d;
        a_neg_rem_q <= a_neg_rem_d;
        a_div0_q    <= a_div0_d;
        a_rs1_q     <= a_rs1_d;
        a_abs1_q    <= a_abs1_d;
        a_abs2_q    <= a_abs2_d;
    end

endmodule

// File: tb/tb_div_pipe_unit.sv
// Bench for div_pipe_unit: directed RV32M cases, pipeline timing scenarios and a randomized
// run, all checked against an in-order queue of results computed with plain arithmetic.
module tb_div_pipe_unit;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_flush = 1'b0;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [1:0]       i_op = 2'd0;
    logic [31:0]      i_rs1 = '0;
    logic [31:0]      i_rs2 = '0;
    logic [TAG_W-1:0] i_tag = '0;
    logic             o_valid;
    logic             i_ready = 1'b1;
    logic [31:0]      o_result;
    logic [TAG_W-1:0] o_tag;

    div_pipe_unit #(.TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             q[$];
    int               nvec = 0;
    int               nerr = 0;
    bit               in_rst = 1'b0;
    bit               stall_prev = 1'b0;
    logic [31:0]      prev_res = '0;
    logic [TAG_W-1:0] prev_tag = '0;

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        case (op)
            2'd0:    return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'd2:    return (b == 0) ? a : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", 32'(o_ready), 32'd0);
            if (in_rst) begin
                chk("rst_valid", 32'(o_valid), 32'd0);
                chk("rst_result", o_result, 32'd0);
                chk("rst_tag", 32'(o_tag), 32'd0);
            end
            q.delete();
            in_rst     = 1'b1;
            stall_prev = 1'b0;
        end else begin
            in_rst = 1'b0;
            chk("ready", 32'(o_ready), 32'((q.size() < 2) || i_ready));
            if (stall_prev) begin
                chk("stall_result", o_result, prev_res);
                chk("stall_tag", 32'(o_tag), 32'(prev_tag));
            end
            if (o_valid) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL spurious_valid: got o_valid=1 expected no pending result");
                end else begin
                    chk("result", o_result, q[0].res);
                    chk("tag", 32'(o_tag), 32'(q[0].tag));
                end
            end
            if (o_valid && i_ready && q.size() > 0) void'(q.pop_front());
            if (i_flush) q.delete();
            if (i_valid && o_ready && !i_flush)
                q.push_back('{res: ref_div(i_op, i_rs1, i_rs2), tag: i_tag});
            stall_prev = o_valid && !i_ready && !i_flush;
            prev_res   = o_result;
            prev_tag   = o_tag;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        chk({nm, "_model"}, ref_div(op, a, b), exp);
        i_ready = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        i_tag   = 5'(nvec);
        i_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_rdy"}, 32'(o_ready), 32'd1);
        step();
        i_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_lat_early"}, 32'(o_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_vld"}, 32'(o_valid), 32'd1);
        chk(nm, o_result, exp);
        step();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return 32'(0 - $urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_rand(input logic [TAG_W-1:0] t);
        i_op  = 2'($urandom_range(0, 3));
        i_rs1 = pick();
        i_rs2 = pick();
        i_tag = t;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(o_ready), 32'd1);
        step();

        lit("div_20_m3",   2'd0, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA);
        lit("rem_20_m3",   2'd2, 32'd20, 32'hFFFF_FFFD, 32'd2);
        lit("rem_m7_2",    2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        lit("divu_big",    2'd1, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF);
        lit("div_5_0",     2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF);
        lit("rem_m5_0",    2'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        lit("remu_9_0",    2'd3, 32'd9, 32'd0, 32'd9);
        lit("divu_0_0",    2'd1, 32'd0, 32'd0, 32'hFFFF_FFFF);
        lit("div_ovf",     2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        lit("rem_ovf",     2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Throughput: 8 ops back to back, tags 0..7
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_valid = 1'b1;
            drive_rand(5'(i));
            @(negedge clk);
            chk("tp_valid", 32'(o_valid), 32'(i >= 2));
            step();
        end
        i_valid = 1'b0;
        @(negedge clk);
        chk("tp_valid_tail6", 32'(o_valid), 32'd1);
        chk("tp_tag6", 32'(o_tag), 32'd6);
        step();
        @(negedge clk);
        chk("tp_valid_tail7", 32'(o_valid), 32'd1);
        chk("tp_tag7", 32'(o_tag), 32'd7);
        step();
        @(negedge clk);
        chk("tp_valid_end", 32'(o_valid), 32'd0);
        step();

        // Backpressure: 5 cycles of i_ready=0 with 3 ops offered
        i_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            i_valid = (idx < 3);
            if (idx < 3) drive_rand(5'(10 + idx));
            @(negedge clk);
            if (c >= 2) chk("bp_ready_low", 32'(o_ready), 32'd0);
            if (o_ready && i_valid) idx++;
            step();
        end
        chk("bp_accepts", 32'(idx), 32'd2);
        i_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            i_valid = 1'b1;
            drive_rand(5'(10 + idx));
            @(negedge clk);
            if (o_ready) idx++;
            step();
        end
        chk("bp_all_accepted", 32'(idx), 32'd3);
        i_valid = 1'b0;
        repeat (4) step();
        chk("bp_drained", 32'(q.size()), 32'd0);

        // Flush with both stages full and a concurrent new op
        i_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1;
            drive_rand(5'(20 + i));
            step();
        end
        i_ready = 1'b1;
        i_flush = 1'b1;
        drive_rand(5'd22);
        @(negedge clk);
        chk("fl_full", 32'(q.size()), 32'd2);
        step();
        i_flush = 1'b0;
        i_valid = 1'b0;
        @(negedge clk);
        chk("fl_valid", 32'(o_valid), 32'd0);
        step();
        @(negedge clk);
        chk("fl_dropped", 32'(o_valid), 32'd0);
        step();

        // Reset pulse mid-stream
        for (int i = 0; i < 2; i++) begin
            i_valid = 1'b1;
            drive_rand(5'(24 + i));
            step();
        end
        rst_n = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_result", o_result, 32'd0);
        step();
        rst_n   = 1'b1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("mrst_ready", 32'(o_ready), 32'd1);
        chk("mrst_no_pulse", 32'(o_valid), 32'd0);
        repeat (3) step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 39) == 0);
            drive_rand(5'($urandom));
            step();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        repeat (6) step();
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
